// File: rtl/chip8_mem_pkg.sv
// Shared types and constants for the CHIP-8 main memory controller.
package chip8_mem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_FONT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam int          FONT_LEN          = 80;
    localparam logic [11:0] DEFAULT_FONT_BASE = 12'h000;
    localparam logic [11:0] DEFAULT_PROG_BASE = 12'h200;

endpackage

// File: rtl/chip8_font_rom.sv
// Standard CHIP-8 hex font: 16 glyphs of 5 rows each, indexed 0..79.
module chip8_font_rom
    import chip8_mem_pkg::*;
(
    input  logic [6:0] index,
    output logic [7:0] glyph
);

    // Byte 0 of the font sits in the most significant byte of the table.
    localparam logic [FONT_LEN*8-1:0] FONT_TABLE = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    logic [6:0] rev_idx_s;

    // Glyph lookup; indices past the font return zero.
    always_comb begin
        rev_idx_s = 7'd0;
        glyph     = 8'h00;
        if (index < 7'(FONT_LEN)) begin
            rev_idx_s = 7'(FONT_LEN - 1) - index;
            glyph     = FONT_TABLE[{rev_idx_s, 3'b000} +: 8];
        end else begin
            rev_idx_s = 7'd0;
            glyph     = 8'h00;
        end
    end

endmodule

// File: rtl/chip8_memory_ctrl.sv
// CHIP-8 main memory: self-initialising dual-port RAM with CPU, program-load
// and video ports. One shared write port, two registered read ports.
module chip8_memory_ctrl
    import chip8_mem_pkg::*;
#(
    parameter int                DATA_W         = 8,
    parameter int                ADDR_W         = 12,
    parameter logic [ADDR_W-1:0] FONT_BASE      = ADDR_W'(DEFAULT_FONT_BASE),
    parameter logic [ADDR_W-1:0] PROG_BASE      = ADDR_W'(DEFAULT_PROG_BASE),
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_en,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_out,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    output logic              load_full,
    output logic              init_done
);

    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam state_t            INIT_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_FONT;
    localparam logic [ADDR_W-1:0] CNT_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] FONT_LAST  = ADDR_W'(FONT_LEN - 1);
    localparam logic [ADDR_W:0]   PTR_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   PTR_START  = {1'b0, PROG_BASE};

    logic [DATA_W-1:0] mem_r [DEPTH];

    state_t            state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W:0]   load_ptr_r;
    logic              init_done_r;
    logic [DATA_W-1:0] a_out_r;
    logic [DATA_W-1:0] b_out_r;

    logic              ready_s;
    logic              load_ready_s;
    logic              load_grant_s;
    logic              a_ready_s;
    logic              a_wr_s;
    logic [7:0]        glyph_s;
    logic              we_s;
    logic [ADDR_W-1:0] wa_s;
    logic [DATA_W-1:0] wd_s;

    chip8_font_rom u_font_rom (
        .index (cnt_r[6:0]),
        .glyph (glyph_s)
    );

    // Handshakes: a coincident load_start suppresses the load write, so it
    // also does not stall the CPU that cycle.
    always_comb begin
        ready_s      = (state_r == ST_READY);
        load_ready_s = ready_s & ~load_ptr_r[ADDR_W];
        load_grant_s = load_valid & load_ready_s & ~load_start;
        a_ready_s    = ready_s & a_en & ~load_grant_s;
        a_wr_s       = a_ready_s & a_write;
    end

    // Single write port arbitration: init engine, then load, then CPU.
    always_comb begin
        we_s = 1'b0;
        wa_s = {ADDR_W{1'b0}};
        wd_s = {DATA_W{1'b0}};
        case (state_r)
            ST_CLEAR: begin
                we_s = reset_n;
                wa_s = cnt_r;
                wd_s = {DATA_W{1'b0}};
            end
            ST_FONT: begin
                we_s = reset_n;
                wa_s = FONT_BASE + cnt_r;
                wd_s = DATA_W'(glyph_s);
            end
            ST_READY: begin
                if (load_grant_s) begin
                    we_s = reset_n;
                    wa_s = load_ptr_r[ADDR_W-1:0];
                    wd_s = DATA_W'(load_data);
                end else if (a_wr_s) begin
                    we_s = reset_n;
                    wa_s = a_addr;
                    wd_s = a_in;
                end else begin
                    we_s = 1'b0;
                end
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Init sequencer and load pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= INIT_STATE;
            cnt_r       <= {ADDR_W{1'b0}};
            load_ptr_r  <= PTR_START;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (&cnt_r) begin
                        state_r <= ST_FONT;
                        cnt_r   <= {ADDR_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_FONT: begin
                    if (cnt_r == FONT_LAST) begin
                        state_r     <= ST_READY;
                        cnt_r       <= {ADDR_W{1'b0}};
                        init_done_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_READY: begin
                    init_done_r <= 1'b1;
                    if (load_start) begin
                        load_ptr_r <= PTR_START;
                    end else if (load_grant_s) begin
                        load_ptr_r <= load_ptr_r + PTR_ONE;
                    end else begin
                        load_ptr_r <= load_ptr_r;
                    end
                end
                default: begin
                    state_r <= INIT_STATE;
                    cnt_r   <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // Registered read ports: A is write-first, B sees pre-write (old) data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_out_r <= {DATA_W{1'b0}};
            b_out_r <= {DATA_W{1'b0}};
        end else begin
            b_out_r <= mem_r[b_addr];
            if (a_ready_s) begin
                a_out_r <= a_write ? a_in : mem_r[a_addr];
            end else begin
                a_out_r <= a_out_r;
            end
        end
    end

    // Array write; contents survive reset and are rebuilt by the init engine.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[wa_s] <= wd_s;
        end
    end

    assign a_out      = a_out_r;
    assign b_out      = b_out_r;
    assign a_ready    = a_ready_s;
    assign load_ready = load_ready_s;
    assign load_full  = load_ptr_r[ADDR_W];
    assign init_done  = init_done_r;

endmodule

// File: tb/tb_chip8_memory_ctrl.sv
// Scoreboard bench for chip8_memory_ctrl: stimulus queues expected read data,
// a monitor pops and compares whenever a port A or port B read completes.
module tb_chip8_memory_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_en = 1'b0;
    logic        a_write = 1'b0;
    logic [11:0] a_addr = 12'h000;
    logic [7:0]  a_in = 8'h00;
    logic [7:0]  a_out;
    logic        a_ready;
    logic [11:0] b_addr = 12'h000;
    logic [7:0]  b_out;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = 8'h00;
    logic        load_ready;
    logic        load_full;
    logic        init_done;
    logic        b_chk = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0] qa [$];
    string      qna [$];
    logic [7:0] qb [$];
    string      qnb [$];

    chip8_memory_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .a_en       (a_en),
        .a_write    (a_write),
        .a_addr     (a_addr),
        .a_in       (a_in),
        .a_out      (a_out),
        .a_ready    (a_ready),
        .b_addr     (b_addr),
        .b_out      (b_out),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_full  (load_full),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: sample handshakes just before the edge, compare data just after.
    initial begin : monitor
        logic acc;
        logic bc;
        forever begin
            @(negedge clk);
            #4;
            acc = a_en & a_ready;
            bc  = b_chk;
            @(posedge clk);
            #1;
            if (acc === 1'b1) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected: got accepted access expected none");
                end else begin
                    check(qna.pop_front(), a_out, qa.pop_front());
                end
            end
            if (bc === 1'b1) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got read expected none");
                end else begin
                    check(qnb.pop_front(), b_out, qb.pop_front());
                end
            end
        end
    end

    task automatic cpu_access(input logic wr, input logic [11:0] addr, input logic [7:0] din,
                              input logic [7:0] exp, input string nm);
        logic got;
        got = 1'b0;
        @(negedge clk);
        a_en = 1'b1; a_write = wr; a_addr = addr; a_in = din;
        qa.push_back(exp); qna.push_back(nm);
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            got = a_ready;
            @(posedge clk);
            if (!got) @(negedge clk);
        end
        @(negedge clk);
        a_en = 1'b0; a_write = 1'b0;
        if (!got) begin
            void'(qa.pop_back());
            void'(qna.pop_back());
            check({nm, "_timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic b_read(input logic [11:0] addr, input logic [7:0] exp, input string nm);
        @(negedge clk);
        b_addr = addr; b_chk = 1'b1;
        qb.push_back(exp); qnb.push_back(nm);
        @(negedge clk);
        b_chk = 1'b0;
    endtask

    task automatic wait_init(input string nm);
        int  n;
        logic saw;
        saw = 1'b0;
        for (n = 1; n <= 5000; n++) begin
            @(posedge clk);
            #1;
            if (init_done) break;
            if (a_ready) saw = 1'b1;
        end
        a_en = 1'b0;
        check({nm, "_cycles"}, n, 32'd4176);
        check({nm, "_a_ready_low"}, {31'd0, saw}, 32'd0);
    endtask

    // Global time limit.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        a_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_out", a_out, 32'h00);
        check("rst_b_out", b_out, 32'h00);
        check("rst_init_done", init_done, 32'd0);
        check("rst_load_full", load_full, 32'd0);
        check("rst_a_ready", a_ready, 32'd0);
        check("rst_load_ready", load_ready, 32'd0);
        reset_n = 1'b1;
        wait_init("init");

        // Font and cleared regions.
        b_read(12'h000, 8'hF0, "font_000");
        b_read(12'h001, 8'h90, "font_001");
        b_read(12'h002, 8'h90, "font_002");
        b_read(12'h003, 8'h90, "font_003");
        b_read(12'h004, 8'hF0, "font_004");
        b_read(12'h005, 8'h20, "font_005");
        b_read(12'h04A, 8'hF0, "font_04A");
        b_read(12'h04B, 8'hF0, "font_04B");
        b_read(12'h04C, 8'h80, "font_04C");
        b_read(12'h04D, 8'hF0, "font_04D");
        b_read(12'h04E, 8'h80, "font_04E");
        b_read(12'h04F, 8'h80, "font_04F");
        b_read(12'h050, 8'h00, "clear_050");
        b_read(12'hFFF, 8'h00, "clear_FFF");

        // Load has priority over the CPU; the stalled read completes later.
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        load_valid = 1'b1; load_data = 8'h12;
        a_en = 1'b1; a_write = 1'b0; a_addr = 12'h200;
        qa.push_back(8'h12); qna.push_back("prio_a_rd_200");
        #1 check("prio_stall_1", a_ready, 32'd0);
        @(negedge clk); load_data = 8'h34;
        #1 check("prio_stall_2", a_ready, 32'd0);
        @(negedge clk); load_valid = 1'b0;
        #1 check("prio_accept", a_ready, 32'd1);
        @(negedge clk); a_en = 1'b0;
        cpu_access(1'b0, 12'h201, 8'h00, 8'h34, "prio_a_rd_201");

        // Plain CPU write then read back.
        cpu_access(1'b1, 12'h0FF, 8'h5C, 8'h5C, "cpu_wr_0FF");
        cpu_access(1'b0, 12'h0FF, 8'h00, 8'h5C, "cpu_rd_0FF");

        // Same-address collision: port B read-first, port A write-first.
        @(negedge clk);
        b_addr = 12'h300; b_chk = 1'b1;
        qb.push_back(8'h00); qnb.push_back("coll_b_old");
        a_en = 1'b1; a_write = 1'b1; a_addr = 12'h300; a_in = 8'hAB;
        qa.push_back(8'hAB); qna.push_back("coll_a_wf");
        @(negedge clk);
        b_chk = 1'b0; a_en = 1'b0; a_write = 1'b0;
        b_read(12'h300, 8'hAB, "coll_b_new");
        cpu_access(1'b0, 12'h300, 8'h00, 8'hAB, "coll_a_rd");

        // Fill PROG_BASE..DEPTH-1 and run into the end of memory.
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0; load_valid = 1'b1;
        for (int i = 0; i < 3584; i++) begin
            load_data = 8'(i) ^ 8'h5A;
            @(negedge clk);
        end
        load_data = 8'hEE;
        #1;
        check("full_flag", load_full, 32'd1);
        check("full_ready", load_ready, 32'd0);
        @(negedge clk);
        @(negedge clk); load_valid = 1'b0;
        b_read(12'hFFF, 8'hA5, "full_FFF_kept");
        b_read(12'h200, 8'h5A, "full_200");
        b_read(12'h345, 8'h1F, "full_345");
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        #1;
        check("restart_full", load_full, 32'd0);
        check("restart_ready", load_ready, 32'd1);

        // Reset in the middle of a load stream.
        @(negedge clk); load_valid = 1'b1; load_data = 8'h11;
        @(negedge clk); load_data = 8'h22;
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1; load_valid = 1'b0;
        #1;
        check("midrst_init_done", init_done, 32'd0);
        check("midrst_load_full", load_full, 32'd0);
        wait_init("reinit");
        b_read(12'h200, 8'h00, "reinit_200");
        b_read(12'h201, 8'h00, "reinit_201");
        b_read(12'h300, 8'h00, "reinit_300");
        b_read(12'h000, 8'hF0, "reinit_font_000");
        b_read(12'h04F, 8'h80, "reinit_font_04F");

        repeat (3) @(negedge clk);
        check("qa_drained", qa.size(), 32'd0);
        check("qb_drained", qb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chip8_memory_ctrl.md
Name: chip8_memory_ctrl

Overview:
Parametrised single-clock dual-port CHIP-8 main memory. It is the successor to the fixed 4 KiB split-nibble BRAM pair and adds three things:
- a self-initialisation engine that clears RAM and writes the hex font after reset;
- a streaming program-load port;
- ready/stall signalling toward the CPU.
Port A serves the CPU (read/write). Port B serves the video scanner (read-only).

Parameters:
DATA_W, 8, memory word width in bits (font writes zero-extend bytes when DATA_W>8)
ADDR_W, 12, address width; DEPTH = 2**ADDR_W
FONT_BASE, 12'h000, first address of the 80-byte hex font
PROG_BASE, 12'h200, first address written by the load port
CLEAR_ON_RESET, 1, 1 = zero the whole array before the font write; 0 = skip the clear phase

Ports:
clk  in  1  single clock, all ports
reset_n  in  1  synchronous active-low reset
a_en  in  1  CPU access request
a_write  in  1  CPU write strobe (qualified by a_en)
a_addr  in  ADDR_W  CPU address
a_in  in  DATA_W  CPU write data
a_out  out  DATA_W  CPU read data
a_ready  out  1  CPU access accepted this cycle
b_addr  in  ADDR_W  video read address
b_out  out  DATA_W  video read data
load_start  in  1  pulse: reset load pointer to PROG_BASE
load_valid  in  1  load byte valid
load_data  in  8  load byte
load_ready  out  1  load byte accepted this cycle
load_full  out  1  load pointer reached DEPTH
init_done  out  1  memory initialised, CPU/load ports live

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-low, on reset_n.
- Reset values: a_out=0, b_out=0, a_ready=0, load_ready=0, load_full=0, init_done=0, state=CLEAR (or FONT if CLEAR_ON_RESET=0), init counter=0, load pointer=PROG_BASE.
- Reset does not alter array contents by itself; the contents are rewritten by the init sequence that follows.
- State machine CLEAR -> FONT -> READY:
  - CLEAR: writes 0 to address cnt, cnt++ each cycle; after the write at DEPTH-1, go to FONT with cnt=0.
  - FONT: writes font_rom[cnt] to FONT_BASE+cnt; after cnt=79, go to READY.
  - READY: init_done=1, held until reset.
- Init timing: init_done rises on the cycle after the last font write, i.e. DEPTH+80 cycles after reset_n rises (80 cycles if CLEAR_ON_RESET=0). In CLEAR and FONT, a_ready=0 and load_ready=0, and CPU/load requests are ignored (not queued).
- Reset mid-init or mid-load: aborts immediately and the sequence restarts from CLEAR.
- Port A (READY only):
  - a_ready = a_en & ~load_grant.
  - Accepted write: mem[a_addr] <= a_in. Write-first: a_out shows a_in on the next cycle.
  - Accepted read: a_out valid 1 cycle after acceptance.
  - Not accepted: a_out holds its previous value.
- Load port (READY only):
  - load_ready = ~load_full.
  - load_grant = load_valid & load_ready. It has priority over port A in the same cycle: the CPU is stalled with a_ready=0 and must hold its request.
  - Granted byte: mem[ptr] <= zero-extended load_data, ptr++.
  - load_full=1 once ptr==DEPTH (pointer is ADDR_W+1 bits, no wrap). Further load_valid is refused.
  - load_start: ptr<=PROG_BASE and load_full<=0. If load_start and load_valid coincide, load_start wins and no write occurs that cycle.
- Port B: always enabled, read-only, b_out=mem[b_addr] 1 cycle later.
  - Same-address collision with a port A/load/init write in the same cycle: b_out returns the OLD data (read-first); the new data is visible on the next read.
- Array: inferred true dual-port RAM, one write port (muxed init/load/CPU) and two read ports. No vendor macros.

Decomposition:
- Package chip8_mem_pkg:
  - state enum {ST_CLEAR, ST_FONT, ST_READY}
  - FONT_LEN=80
  - default FONT_BASE/PROG_BASE constants
- Sub-module chip8_font_rom: combinational 7-bit index -> 8-bit glyph row. Contents are the standard 0-F font (0: F0 90 90 90 F0, 1: 20 60 20 20 70, ... F: F0 80 F0 80 80).

Test Plan:
- Init timing: release reset with defaults -> init_done rises exactly 4096+80 cycles later; a_ready stays 0 throughout despite a_en=1.
- Font/clear contents: after init, port B reads 0x000-0x004 -> F0,90,90,90,F0; reads 0x04B-0x04F -> F0,80,F0,80,80; reads 0x050 and 0xFFF -> 00.
- Load priority: load_start, then stream 0x12,0x34 while the CPU requests a read of 0x200 -> a_ready=0 on both grant cycles; the CPU read accepted afterwards returns 0x12; 0x201 reads 0x34.
- Load full: stream 3584 bytes -> load_full=1 after the last byte and load_ready=0; a further load_valid leaves 0xFFF unchanged; load_start clears load_full.
- Collision: CPU writes 0xAB to 0x300 while b_addr=0x300 (old value 00) -> b_out=00 next cycle; the following read gives 0xAB; a_out=0xAB (write-first).
- Reset mid-load: assert reset_n=0 for 1 cycle during streaming -> init_done=0 next cycle, the full clear+font sequence reruns, and previously loaded bytes read 00.
